// File: rtl/hci_package.sv
// Shared defaults and index helpers for the HCI round-robin arbiter slice.
package hci_package;

   localparam int unsigned DEFAULT_N_INIT          = 2;
   localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;

   // Cyclic index step, used for both candidate scanning and pointer advance.
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned n);
      return (base + step) % n;
   endfunction

endpackage

// File: rtl/hci_arb_route_fifo.sv
// In-order route FIFO: remembers which initiator owns each outstanding
// transaction so responses can be steered back without buffering data.
module hci_arb_route_fifo
   import hci_package::*;
#(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PW-1:0]           wr_q, rd_q;
   logic [CW-1:0]           cnt_q;
   logic                    do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];

   // Guards keep the occupancy honest even if a caller ignores full/empty.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/hci_rr_arbiter.sv
// Round-robin N:1 HCI arbiter with in-order response routing.
// Build option: HCI_ARB_ERR_CHECK_EN enables the sticky unexpected-response flag.
module hci_rr_arbiter
   import hci_package::*;
#(
   parameter int unsigned N_INIT          = DEFAULT_N_INIT,
   parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   parameter int unsigned DW              = 32,
   parameter int unsigned AW              = 32,
   parameter int unsigned BW              = DW / 8,
   parameter int unsigned UW              = 1,
   parameter int unsigned IW              = 8,
   parameter int unsigned EW              = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   // requester side
   input  logic [N_INIT-1:0]            in_req,
   output logic [N_INIT-1:0]            in_gnt,
   input  logic [N_INIT-1:0][AW-1:0]    in_add,
   input  logic [N_INIT-1:0]            in_wen,
   input  logic [N_INIT-1:0][DW-1:0]    in_data,
   input  logic [N_INIT-1:0][BW-1:0]    in_be,
   input  logic [N_INIT-1:0][UW-1:0]    in_user,
   input  logic [N_INIT-1:0][IW-1:0]    in_id,
   input  logic [N_INIT-1:0][EW-1:0]    in_ecc,
   input  logic [N_INIT-1:0]            in_ereq,
   output logic [N_INIT-1:0]            in_egnt,
   output logic [N_INIT-1:0]            in_r_valid,
   input  logic [N_INIT-1:0]            in_r_ready,
   output logic [N_INIT-1:0][DW-1:0]    in_r_data,
   output logic [N_INIT-1:0][UW-1:0]    in_r_user,
   output logic [N_INIT-1:0][IW-1:0]    in_r_id,
   output logic [N_INIT-1:0]            in_r_opc,
   output logic [N_INIT-1:0][EW-1:0]    in_r_ecc,
   output logic [N_INIT-1:0]            in_r_evalid,
   input  logic [N_INIT-1:0]            in_r_eready,
   // shared target side
   output logic                         out_req,
   input  logic                         out_gnt,
   output logic [AW-1:0]                out_add,
   output logic                         out_wen,
   output logic [DW-1:0]                out_data,
   output logic [BW-1:0]                out_be,
   output logic [UW-1:0]                out_user,
   output logic [IW-1:0]                out_id,
   output logic [EW-1:0]                out_ecc,
   output logic                         out_ereq,
   input  logic                         out_egnt,
   input  logic                         out_r_valid,
   output logic                         out_r_ready,
   input  logic [DW-1:0]                out_r_data,
   input  logic [UW-1:0]                out_r_user,
   input  logic [IW-1:0]                out_r_id,
   input  logic                         out_r_opc,
   input  logic [EW-1:0]                out_r_ecc,
   input  logic                         out_r_evalid,
   output logic                         out_r_eready,
   output logic                         err_o
);

   localparam int unsigned IDX_W = $clog2(N_INIT);

   if (N_INIT < 2 || N_INIT > 8) begin : g_bad_n_init
      $error("hci_rr_arbiter: N_INIT must be in 2..8");
   end
   if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
      $error("hci_rr_arbiter: MAX_OUTSTANDING must be a power of two >= 2");
   end

   logic [IDX_W-1:0] ptr_q, sel_q, rr_sel, sel, head;
   logic             lock_q, rr_found, any_req, hs, pop;
   logic             fifo_full, fifo_empty;

   // Lowest requesting index at or after ptr, scanning cyclically.
   always_comb begin
      rr_sel   = ptr_q;
      rr_found = 1'b0;
      for (int k = 0; k < N_INIT; k++) begin
         if (!rr_found && in_req[IDX_W'(wrap_add(int'(ptr_q), k, N_INIT))]) begin
            rr_sel   = IDX_W'(wrap_add(int'(ptr_q), k, N_INIT));
            rr_found = 1'b1;
         end
      end
   end

   // A stalled request keeps its owner so the payload on out stays stable.
   assign sel     = lock_q ? sel_q : rr_sel;
   assign any_req = |in_req;
   assign out_req = any_req & ~fifo_full & rst_ni;
   assign hs      = out_req & out_gnt;

   assign out_add  = in_add[sel];
   assign out_wen  = in_wen[sel];
   assign out_data = in_data[sel];
   assign out_be   = in_be[sel];
   assign out_user = in_user[sel];
   assign out_id   = in_id[sel];
   assign out_ecc  = in_ecc[sel];
   assign out_ereq = in_ereq[sel] & out_req;

   always_comb begin
      in_gnt       = '0;
      in_egnt      = '0;
      in_gnt[sel]  = hs;
      in_egnt[sel] = out_egnt & out_req;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q  <= '0;
         sel_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         lock_q <= out_req & ~out_gnt;
         if (out_req && !out_gnt) sel_q <= sel;
         if (hs) ptr_q <= IDX_W'(wrap_add(int'(sel), 1, N_INIT));
      end
   end

   hci_arb_route_fifo #(
      .W     (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_route_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (hs),
      .data_i  (sel),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Response payload is broadcast; only the owner sees valid.
   assign in_r_data = {N_INIT{out_r_data}};
   assign in_r_user = {N_INIT{out_r_user}};
   assign in_r_id   = {N_INIT{out_r_id}};
   assign in_r_opc  = {N_INIT{out_r_opc}};
   assign in_r_ecc  = {N_INIT{out_r_ecc}};

   always_comb begin
      in_r_valid  = '0;
      in_r_evalid = '0;
      if (!fifo_empty) begin
         in_r_valid[head]  = out_r_valid;
         in_r_evalid[head] = out_r_evalid;
      end
   end

   assign out_r_ready  = ~fifo_empty & in_r_ready[head];
   assign out_r_eready = ~fifo_empty & in_r_eready[head];
   assign pop          = out_r_valid & out_r_ready;

`ifdef HCI_ARB_ERR_CHECK_EN
   logic err_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_q | (out_r_valid & fifo_empty);
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hci_rr_arbiter.sv
// Directed bench for hci_rr_arbiter (N_INIT=2, MAX_OUTSTANDING=4).
module tb_hci_rr_arbiter;

   localparam int N = 2, DW = 32, AW = 32, BW = 4, UW = 1, IW = 8, EW = 1;
`ifdef HCI_ARB_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic clk_i = 1'b0, rst_ni;
   logic [N-1:0]         in_req, in_gnt, in_wen, in_ereq, in_egnt;
   logic [N-1:0]         in_r_valid, in_r_ready, in_r_opc, in_r_evalid, in_r_eready;
   logic [N-1:0][AW-1:0] in_add;
   logic [N-1:0][DW-1:0] in_data, in_r_data;
   logic [N-1:0][BW-1:0] in_be;
   logic [N-1:0][UW-1:0] in_user, in_r_user;
   logic [N-1:0][IW-1:0] in_id, in_r_id;
   logic [N-1:0][EW-1:0] in_ecc, in_r_ecc;
   logic          out_req, out_gnt, out_wen, out_ereq, out_egnt;
   logic          out_r_valid, out_r_ready, out_r_opc, out_r_evalid, out_r_eready, err_o;
   logic [AW-1:0] out_add;
   logic [DW-1:0] out_data, out_r_data;
   logic [BW-1:0] out_be;
   logic [UW-1:0] out_user, out_r_user;
   logic [IW-1:0] out_id, out_r_id;
   logic [EW-1:0] out_ecc, out_r_ecc;

   int npass = 0, nfail = 0, ntot = 0;

   always #5 clk_i = ~clk_i;

   hci_rr_arbiter #(.N_INIT(N), .MAX_OUTSTANDING(4), .DW(DW), .AW(AW), .BW(BW),
                    .UW(UW), .IW(IW), .EW(EW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
      .in_data(in_data), .in_be(in_be), .in_user(in_user), .in_id(in_id),
      .in_ecc(in_ecc), .in_ereq(in_ereq), .in_egnt(in_egnt),
      .in_r_valid(in_r_valid), .in_r_ready(in_r_ready), .in_r_data(in_r_data),
      .in_r_user(in_r_user), .in_r_id(in_r_id), .in_r_opc(in_r_opc),
      .in_r_ecc(in_r_ecc), .in_r_evalid(in_r_evalid), .in_r_eready(in_r_eready),
      .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
      .out_data(out_data), .out_be(out_be), .out_user(out_user), .out_id(out_id),
      .out_ecc(out_ecc), .out_ereq(out_ereq), .out_egnt(out_egnt),
      .out_r_valid(out_r_valid), .out_r_ready(out_r_ready), .out_r_data(out_r_data),
      .out_r_user(out_r_user), .out_r_id(out_r_id), .out_r_opc(out_r_opc),
      .out_r_ecc(out_r_ecc), .out_r_evalid(out_r_evalid), .out_r_eready(out_r_eready),
      .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) begin
         npass++;
      end else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, then let inputs settle.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni = 1'b0;
      in_req = 2'b11; in_wen = '0; in_ereq = '0; in_r_ready = 2'b11; in_r_eready = '0;
      in_add[0] = 32'h80; in_add[1] = 32'h40;
      in_data = '0; in_be = '0; in_user = '0; in_id = '0; in_ecc = '0;
      out_gnt = 1'b0; out_egnt = 1'b0; out_r_valid = 1'b1; out_r_data = '0;
      out_r_user = '0; out_r_id = '0; out_r_opc = 1'b0; out_r_ecc = '0; out_r_evalid = 1'b0;
      #3;
      chk("rst_out_req", out_req, 0);
      chk("rst_in_gnt", in_gnt, 0);
      chk("rst_in_r_valid", in_r_valid, 0);
      chk("rst_out_r_ready", out_r_ready, 0);
      chk("rst_err", err_o, 0);
      out_r_valid = 1'b0; in_req = '0;
      cyc(); cyc();
      rst_ni = 1'b1;

      // Both requesting, target always ready: grants alternate.
      in_req = 2'b11; in_ereq = 2'b11; out_gnt = 1'b1; out_egnt = 1'b1;
      #1;
      chk("rr0_gnt", in_gnt, 2'b01);
      chk("rr0_egnt", in_egnt, 2'b01);
      chk("rr0_add", out_add, 32'h80);
      cyc(); chk("rr1_gnt", in_gnt, 2'b10); chk("rr1_add", out_add, 32'h40);
      cyc(); chk("rr2_gnt", in_gnt, 2'b01);
      cyc(); chk("rr3_gnt", in_gnt, 2'b10);
      cyc();
      chk("full_out_req", out_req, 0);
      chk("full_in_gnt", in_gnt, 2'b00);
      // Pop while full: request stays blocked this cycle.
      out_r_valid = 1'b1; out_r_data = 32'hA; #1;
      chk("pop_full_rvalid", in_r_valid, 2'b01);
      chk("pop_full_rdata", in_r_data[0], 32'hA);
      chk("pop_full_rready", out_r_ready, 1);
      chk("pop_full_out_req", out_req, 0);
      cyc();
      out_r_valid = 1'b0; #1;
      chk("resume_out_req", out_req, 1);
      chk("resume_gnt_ptr0", in_gnt, 2'b01);
      cyc();

      // Drain four responses: owners 1,0,1,0; in1 stalls first.
      in_req = '0; in_ereq = '0; out_gnt = 1'b0;
      out_r_valid = 1'b1; out_r_data = 32'hB; in_r_ready = 2'b01; #1;
      chk("stall_rvalid", in_r_valid, 2'b10);
      chk("stall_rready", out_r_ready, 0);
      cyc();
      chk("stall2_rready", out_r_ready, 0);
      in_r_ready = 2'b11; #1;
      chk("unstall_rready", out_r_ready, 1);
      chk("unstall_rdata", in_r_data[1], 32'hB);
      cyc();
      out_r_data = 32'hC; #1; chk("resp_c_rvalid", in_r_valid, 2'b01);
      cyc();
      out_r_data = 32'hD; #1; chk("resp_d_rvalid", in_r_valid, 2'b10);
      cyc();
      out_r_data = 32'hE; #1; chk("resp_e_rvalid", in_r_valid, 2'b01);
      cyc();

      // Response with nothing outstanding.
      out_r_data = 32'hF; #1;
      chk("empty_rvalid", in_r_valid, 2'b00);
      chk("empty_rready", out_r_ready, 0);
      cyc();
      out_r_valid = 1'b0; #1;
      chk("err_flag", err_o, ERR_EXP);

      // ptr is 1 here; one in1 grant moves it to 0 before the lock test.
      in_req = 2'b10; out_gnt = 1'b1; #1;
      chk("pre_lock_gnt", in_gnt, 2'b10);
      cyc();
      out_gnt = 1'b0; #1;
      chk("lock1_out_req", out_req, 1);
      chk("lock1_add", out_add, 32'h40);
      chk("lock1_gnt", in_gnt, 2'b00);
      cyc();
      in_req = 2'b11; #1;
      chk("lock2_add", out_add, 32'h40);
      cyc();
      chk("lock3_add", out_add, 32'h40);
      chk("lock3_gnt", in_gnt, 2'b00);
      cyc();
      out_gnt = 1'b1; #1;
      chk("lock4_gnt", in_gnt, 2'b10);
      cyc();
      chk("lock5_gnt", in_gnt, 2'b01);
      chk("lock5_add", out_add, 32'h80);
      cyc();

      // Reset with three entries outstanding and ptr=1.
      out_r_valid = 1'b1; rst_ni = 1'b0; #1;
      chk("mid_rst_out_req", out_req, 0);
      chk("mid_rst_gnt", in_gnt, 2'b00);
      chk("mid_rst_rvalid", in_r_valid, 2'b00);
      chk("mid_rst_err", err_o, 0);
      #2 rst_ni = 1'b1; #1;
      chk("post_rst_gnt", in_gnt, 2'b01);
      chk("post_rst_rvalid", in_r_valid, 2'b00);
      chk("post_rst_rready", out_r_ready, 0);
      cyc();
      out_r_valid = 1'b0; #1;
      chk("post_rst_gnt2", in_gnt, 2'b10);
      cyc();
      in_req = '0; out_r_valid = 1'b1; out_r_data = 32'h5; #1;
      chk("post_rst_resp0", in_r_valid, 2'b01);
      chk("post_rst_rdata", in_r_data[0], 32'h5);
      cyc();
      chk("post_rst_resp1", in_r_valid, 2'b10);
      cyc();
      out_r_valid = 1'b0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hci_rr_arbiter.md
HCI_RR_ARBITER -- requirements
Module: hci_rr_arbiter

Interface
REQ-001 Parameter N_INIT, default 2: number of initiator ports sharing one target, range 2..8.
REQ-002 Parameter MAX_OUTSTANDING, default 4: route-FIFO depth, i.e. max granted-but-unanswered transactions, power of two, minimum 2.
REQ-003 Port clk_i  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_ni  input  1: one clock; reset is asynchronous and active-low.
REQ-005 Port in  hci_core_intf.target  [N_INIT]: requester-side HCI ports.
REQ-006 Port out  hci_core_intf.initiator  1: shared target-side HCI port, same DW/AW/BW/UW/IW/EW as in.
REQ-007 Port err_o  output  1: sticky response-routing error flag (see REQ-027).

Function
REQ-008 Selection: round-robin among in[i].req starting at pointer ptr; lowest index at or after ptr (cyclic) wins.
REQ-009 out.req = (any in[i].req) & ~fifo_full; out.add/wen/data/be/user/id/ecc = payload of selected index sel.
REQ-010 in[sel].gnt = out.gnt & out.req; all other in[i].gnt = 0; combinational, zero-cycle latency.
REQ-011 Lock: if out.req=1 and out.gnt=0, sel is registered and held on the next cycle regardless of other requests, guaranteeing request payload stability and no retirement.
REQ-012 Lock releases on out.req & out.gnt; ptr <= (sel+1) mod N_INIT at that edge.
REQ-013 ptr is unchanged when no handshake occurs.
REQ-014 Every granted transaction (load and store) returns exactly one response, in order.
REQ-015 On out.req & out.gnt, sel is pushed into the route FIFO.
REQ-016 Response routing: head = FIFO head index; in[head].r_valid = out.r_valid; in[head].r_data/r_user/r_id/r_opc/r_ecc = out equivalents; other in[i].r_valid = 0.
REQ-017 out.r_ready = in[head].r_ready when FIFO non-empty.
REQ-018 FIFO pops on out.r_valid & out.r_ready.
REQ-019 Zero-cycle response latency; no response buffering in the block.
REQ-020 Full: fifo_full blocks out.req and all grants. A same-cycle pop does not unblock; grant resumes the following cycle.
REQ-021 Simultaneous push and pop when not full: occupancy unchanged; both take effect.
REQ-022 Empty FIFO: out.r_ready = 0, all in[i].r_valid = 0.
REQ-023 Pointer/FIFO index wrap: modulo N_INIT and MAX_OUTSTANDING respectively; occupancy counter is clog2(MAX_OUTSTANDING)+1 bits.
REQ-024 Handshake ECC signals ereq/egnt/r_evalid/r_eready are passed through for sel/head under the same rules as req/gnt/r_valid/r_ready.

Reset
REQ-025 On rst_ni low, asynchronously: ptr=0, lock cleared, FIFO empty, err_o=0; out.req=0, all in[i].gnt=0, all in[i].r_valid=0 while reset is asserted.
REQ-026 Reset mid-operation discards in-flight routing entries; responses arriving afterwards fall under REQ-022/REQ-027.

Configuration
REQ-027 Macro HCI_ARB_ERR_CHECK_EN defined: err_o sets on out.r_valid=1 with FIFO empty and stays set until reset. Undefined: err_o tied 0 and no detection logic is generated.

Structure
REQ-028 hci_package holds DEFAULT_MAX_OUTSTANDING (4) and DEFAULT_N_INIT (2).
REQ-029 Route FIFO is sub-module hci_arb_route_fifo with width clog2(N_INIT), depth MAX_OUTSTANDING, and push/pop/full/empty/head ports.
REQ-030 Selection, lock and pointer logic reside in hci_rr_arbiter.

Verification
REQ-031 Scenario: N_INIT=2, both req=1 continuously, out.gnt=1 -> grants alternate in0,in1,in0,in1; ptr after 4 grants = 0.
REQ-032 Scenario: in1 req with add=0x40, out.gnt=0 for 3 cycles, in0 raises req in cycle 2 -> out.add stays 0x40, in1 granted in cycle 4, in0 granted next.
REQ-033 Scenario: MAX_OUTSTANDING=4, 4 grants with no responses -> out.req=0 on cycle 5; one response popped -> grant resumes the cycle after the pop.
REQ-034 Scenario: grants order in0,in1,in0; three responses r_data=0xA,0xB,0xC -> delivered to in0,in1,in0 respectively; in1.r_ready=0 stalls out.r_ready=0 until raised.
REQ-035 Scenario: out.r_valid=1 with FIFO empty -> no in[i].r_valid; err_o=1 with HCI_ARB_ERR_CHECK_EN, 0 without.
REQ-036 Scenario: rst_ni pulled low with 2 entries outstanding -> FIFO empty, ptr=0, outputs at reset values immediately; normal arbitration from first cycle after release.
